// File: rtl/data_mem_responder_if.sv
// Data-memory request/response bundle between the MEM stage (master) and the memory responder (slave).
interface data_mem_responder_if;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic        err;

  modport master (
    output mem_r_en, mem_w_en, address, write_data,
    input  read_data, ready, err
  );

  modport slave (
    input  mem_r_en, mem_w_en, address, write_data,
    output read_data, ready, err
  );
endinterface

// File: rtl/data_mem_responder.sv
// SRAM-style data memory: latches a load/store, waits WAIT_CYCLES, performs it,
// and holds the pipeline off through ready until the access has completed.
module data_mem_responder #(
  parameter logic [31:0] ADDR_BASE   = 32'd1024,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 4
) (
  input logic                 clk,
  input logic                 rst,
  data_mem_responder_if.slave bus
);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        lat_addr;
  logic [31:0]        lat_data;
  logic               lat_wr;
  logic               lat_both;
  logic [31:0]        mem [DEPTH];

  logic               req;
  logic [31:0]        offset;
  logic [31:0]        word_off;
  logic               in_range;
  logic [IDX_W-1:0]   idx;
  logic               fire;
  logic               do_write;

  assign req       = bus.mem_r_en | bus.mem_w_en;
  assign bus.ready = (state == DONE) | ((state == IDLE) & ~req);

  // Unsigned wrap below ADDR_BASE is caught by the explicit lower-bound compare.
  assign offset    = lat_addr - ADDR_BASE;
  assign word_off  = offset >> 2;
  assign in_range  = (lat_addr >= ADDR_BASE) && (word_off < 32'(DEPTH));
  assign idx       = word_off[IDX_W-1:0];
  assign fire      = (state == WAIT) && (cnt == '0);
  assign do_write  = fire && lat_wr && in_range;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      lat_addr      <= '0;
      lat_data      <= '0;
      lat_wr        <= 1'b0;
      lat_both      <= 1'b0;
      bus.read_data <= '0;
      bus.err       <= 1'b0;
    end else begin
      bus.err <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            lat_addr <= bus.address;
            lat_data <= bus.write_data;
            lat_wr   <= bus.mem_w_en;
            lat_both <= bus.mem_r_en & bus.mem_w_en;
            cnt      <= CNT_W'(WAIT_CYCLES - 1);
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            if (!lat_wr) begin
              bus.read_data <= in_range ? mem[idx] : 32'h0;
            end
            bus.err <= ~in_range | lat_both;
            state   <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Array has no reset; an in-flight write is discarded because reset leaves WAIT.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[idx] <= lat_data;
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: expectations queued at request time,
// checked when ready marks the DONE cycle.
module tb_data_mem_responder;
  localparam int unsigned WAITS = 4;

  typedef struct {
    string       tag;
    int          lows;
    logic [31:0] rd;
    logic        err;
  } exp_t;

  logic clk;
  logic rst;
  data_mem_responder_if bus ();

  data_mem_responder #(
    .ADDR_BASE  (32'd1024),
    .DEPTH      (64),
    .WAIT_CYCLES(WAITS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  exp_t        sb[$];
  logic [31:0] model [64];
  logic [31:0] model_rd;
  int          n_checks = 0;
  int          n_pass   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One access from IDLE; drop_at >= 0 clears the request and scrambles inputs mid-WAIT.
  task automatic access(input string tag, input bit r, input bit w,
                        input logic [31:0] a, input logic [31:0] d, input int drop_at);
    logic [31:0] off;
    bit          inr;
    int          idx;
    exp_t        e;
    exp_t        got_e;
    int          lows;
    bit          early_err;

    off = a - 32'd1024;
    inr = (a >= 32'd1024) && ((off >> 2) < 32'd64);
    idx = int'(off >> 2);
    e.tag  = tag;
    e.lows = WAITS + 1;
    e.err  = !inr || (r && w);
    if (w) begin
      if (inr) model[idx] = d;
      e.rd = model_rd;
    end else begin
      e.rd     = inr ? model[idx] : 32'h0;
      model_rd = e.rd;
    end

    @(negedge clk);
    bus.mem_r_en   = r;
    bus.mem_w_en   = w;
    bus.address    = a;
    bus.write_data = d;
    sb.push_back(e);

    lows      = 0;
    early_err = 1'b0;
    forever begin
      #1;
      if (bus.ready) break;
      if (bus.err) early_err = 1'b1;
      lows++;
      if (lows > 100) break;
      @(negedge clk);
      if (lows == drop_at) begin
        bus.mem_r_en   = 1'b0;
        bus.mem_w_en   = 1'b0;
        bus.address    = 32'hFFFF_0000;
        bus.write_data = $urandom;
      end
    end

    got_e = sb.pop_front();
    check({got_e.tag, "_latency"}, 32'(lows), 32'(got_e.lows));
    check({got_e.tag, "_early_err"}, 32'(early_err), 32'h0);
    check({got_e.tag, "_err"}, 32'(bus.err), 32'(got_e.err));
    check({got_e.tag, "_rdata"}, bus.read_data, got_e.rd);
  endtask

  // Request dropped after DONE: must be back in IDLE, not restarted, err cleared.
  task automatic idle(input string tag);
    @(negedge clk);
    bus.mem_r_en = 1'b0;
    bus.mem_w_en = 1'b0;
    #1;
    check({tag, "_idle_ready"}, 32'(bus.ready), 32'h1);
    check({tag, "_idle_err"}, 32'(bus.err), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) model[i] = 32'h0;
    model_rd       = 32'h0;
    rst            = 1'b0;
    bus.mem_r_en   = 1'b0;
    bus.mem_w_en   = 1'b0;
    bus.address    = 32'h0;
    bus.write_data = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", 32'(bus.ready), 32'h1);
    check("rst_rdata", bus.read_data, 32'h0);
    check("rst_err", 32'(bus.err), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Basic store then load
    access("t1_st", 1'b0, 1'b1, 32'd1024, 32'hDEAD_BEEF, -1);
    idle("t1_st");
    access("t1_ld", 1'b1, 1'b0, 32'd1024, 32'h0, -1);
    idle("t1_ld");

    // Back-to-back: load issued in the cycle right after DONE
    access("t2_st", 1'b0, 1'b1, 32'd1028, 32'h0000_0011, -1);
    access("t2_ld", 1'b1, 1'b0, 32'd1028, 32'h0, -1);
    idle("t2_ld");

    // Out-of-range accesses leave word 63 untouched
    access("t3_pre", 1'b0, 1'b1, 32'd1276, 32'hCAFE_0063, -1);
    idle("t3_pre");
    access("t3_ld_hi", 1'b1, 1'b0, 32'd1280, 32'h0, -1);
    idle("t3_ld_hi");
    access("t3_ld63", 1'b1, 1'b0, 32'd1276, 32'h0, -1);
    idle("t3_ld63");
    access("t3_st_lo", 1'b0, 1'b1, 32'd1020, 32'h5555_AAAA, -1);
    idle("t3_st_lo");
    access("t3_chk63", 1'b1, 1'b0, 32'd1276, 32'h0, -1);
    idle("t3_chk63");

    // Reset during WAIT discards the store
    access("t4_pre", 1'b0, 1'b1, 32'd1032, 32'h0, -1);
    idle("t4_pre");
    @(negedge clk);
    bus.mem_w_en   = 1'b1;
    bus.address    = 32'd1032;
    bus.write_data = 32'h1234_5678;
    repeat (2) @(negedge clk);
    rst          = 1'b0;
    bus.mem_w_en = 1'b0;
    #1;
    check("t4_rst_ready", 32'(bus.ready), 32'h1);
    check("t4_rst_rdata", bus.read_data, 32'h0);
    check("t4_rst_err", 32'(bus.err), 32'h0);
    model_rd = 32'h0;
    @(negedge clk);
    rst = 1'b1;
    access("t4_ld", 1'b1, 1'b0, 32'd1032, 32'h0, -1);
    idle("t4_ld");

    // Both enables: store wins, err pulses, read_data held
    access("t5_pre", 1'b1, 1'b0, 32'd1028, 32'h0, -1);
    idle("t5_pre");
    access("t5_both", 1'b1, 1'b1, 32'd1036, 32'hA5A5_A5A5, -1);
    idle("t5_both");
    access("t5_ld", 1'b1, 1'b0, 32'd1036, 32'h0, -1);
    idle("t5_ld");

    // Flush mid-WAIT still completes; low address bits ignored
    access("t6_flush", 1'b1, 1'b0, 32'd1028, 32'h0, 3);
    idle("t6_flush");
    access("t6_st", 1'b0, 1'b1, 32'd1026, 32'h0BAD_F00D, 2);
    idle("t6_st");
    access("t6_ld", 1'b1, 1'b0, 32'd1024, 32'h0, -1);
    idle("t6_ld");

    check("sb_empty", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
